// File: rtl/dcmi_pkg.sv
// dcmi_pkg: shared state encoding and default word FIFO depth for the DCMI write scheduler
package dcmi_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/dcmi_wfifo.sv
// dcmi_wfifo: synchronous word FIFO with count-based full/empty and a combinational head
module dcmi_wfifo import dcmi_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  // storage write at the tail
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  // pointers and occupancy; flush empties in one cycle
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/dcmi_wr_sched.sv
// dcmi_wr_sched: buffers camera words and schedules RAM writes over a start/length window
module dcmi_wr_sched import dcmi_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        hclk,
  input  logic        rst,
  input  logic        dma_en,
  input  logic        circ_mode,
  input  logic        frame_start,
  input  logic [17:0] dma_saddr,
  input  logic [17:0] dma_len,
  input  logic        in_vld,
  input  logic [31:0] in_data,
  output logic        ram_wr_req,
  input  logic        ram_wr_ack,
  output logic [23:0] ram_waddr,
  output logic [31:0] ram_wdata,
  output logic        busy,
  output logic        half_done,
  output logic        xfer_done,
  output logic        ovfl_err
);
  state_t state, nxt;
  logic [15:0] base, words, count, sh_base, sh_words, cnt_n, nw;
  logic pend, held, full, empty, push, pop, flush, apply, restart, ack_ok, push_try;
  logic done_n, half_n, ovf_n, unused;
  logic [31:0] head;
  dcmi_wfifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk(hclk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .din(in_data), .dout(head), .full(full), .empty(empty)
  );
  // a deferred restart masks new requests once the in-flight one has been acked
  assign ram_wr_req = state == RUN && !empty && (!pend || held);
  assign ack_ok = ram_wr_req && ram_wr_ack;
  assign restart = frame_start || pend;
  assign apply = restart && dma_en && state != IDLE && !ram_wr_req;
  assign nw = frame_start ? dma_len[17:2] : sh_words;
  assign push_try = in_vld && state == RUN;
  assign pop = ack_ok || (state == DONE && !empty);
  assign push = push_try && (!full || pop);
  assign ovf_n = !flush && ((push_try && full && !pop) || (state == DONE && !empty));
  assign ram_waddr = {6'b0, base + count, 2'b00};
  assign ram_wdata = ram_wr_req ? head : '0;
  assign busy = state == ARMED || state == RUN;
  assign unused = ^{dma_saddr[1:0], dma_len[1:0]};
  // next state, word counter and completion pulses
  always_comb begin
    nxt = state;
    flush = 1'b0;
    cnt_n = count;
    done_n = 1'b0;
    half_n = 1'b0;
    if (!dma_en && (!ram_wr_req || ram_wr_ack)) begin
      nxt = IDLE;
      flush = 1'b1;
      cnt_n = '0;
    end else if (apply) begin
      nxt = nw == '0 ? DONE : RUN;
      flush = 1'b1;
      cnt_n = '0;
      done_n = nw == '0;
    end else if (state == IDLE) begin
      nxt = ARMED;
    end else if (ack_ok) begin
      half_n = words > 16'd1 && count == (words >> 1) - 16'd1;
      done_n = count == words - 16'd1;
      cnt_n = done_n ? '0 : count + 16'd1;
      nxt = (done_n && !circ_mode) ? DONE : state;
    end
  end
  // state, window latches, restart deferral and registered pulses
  always_ff @(posedge hclk)
    if (rst) begin
      state <= IDLE;
      base <= '0;
      words <= '0;
      count <= '0;
      sh_base <= '0;
      sh_words <= '0;
      pend <= 1'b0;
      held <= 1'b0;
      half_done <= 1'b0;
      xfer_done <= 1'b0;
      ovfl_err <= 1'b0;
    end else begin
      state <= nxt;
      count <= cnt_n;
      pend <= restart && dma_en && state != IDLE && ram_wr_req;
      held <= ram_wr_req && !ram_wr_ack;
      half_done <= half_n;
      xfer_done <= done_n;
      ovfl_err <= ovf_n;
      if (frame_start) begin
        sh_base <= dma_saddr[17:2];
        sh_words <= dma_len[17:2];
      end
      if (apply) begin
        base <= frame_start ? dma_saddr[17:2] : sh_base;
        words <= nw;
      end
    end
endmodule

// File: doc/dcmi_wr_sched.md
DCMI_WR_SCHED -- requirements
Module: dcmi_wr_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input word FIFO depth (power of 2, >=2).
REQ-002 SHALL have port hclk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port dma_en  in  1  level, enables scheduler.
REQ-005 SHALL have port circ_mode  in  1  1: restart at dma_saddr after last word; 0: stop.
REQ-006 SHALL have port frame_start  in  1  one-cycle pulse; arms/restarts transfer.
REQ-007 SHALL have port dma_saddr  in  18  byte start address; bits[1:0] ignored.
REQ-008 SHALL have port dma_len  in  18  byte length; bits[1:0] ignored; words = dma_len[17:2].
REQ-009 SHALL have port in_vld  in  1  input word strobe; no backpressure.
REQ-010 SHALL have port in_data  in  32  input word.
REQ-011 SHALL have port ram_wr_req  out  1  RAM write request.
REQ-012 SHALL have port ram_wr_ack  in  1  RAM write accept, same-cycle with req.
REQ-013 SHALL have port ram_waddr  out  24  byte address, {6'b0, addr18}.
REQ-014 SHALL have port ram_wdata  out  32  write data.
REQ-015 SHALL have port busy  out  1  high in ARMED/RUN.
REQ-016 SHALL have port half_done  out  1  pulse when word count reaches words/2 (integer).
REQ-017 SHALL have port xfer_done  out  1  pulse when last word acked.
REQ-018 SHALL have port ovfl_err  out  1  pulse when an input word is dropped.

Function
REQ-019 SHALL implement states IDLE, ARMED, RUN, DONE.
REQ-020 SHALL go IDLE->ARMED when dma_en=1; any state ->IDLE when dma_en=0 and no handshake pending.
REQ-021 SHALL, on frame_start in ARMED/RUN/DONE, latch saddr/len, clear offset and word count, flush FIFO, enter RUN; if words=0, enter DONE and pulse xfer_done next cycle.
REQ-022 SHALL accept in_vld only in RUN; in_vld in ARMED/DONE is discarded silently.
REQ-023 SHALL push in_data into FIFO on in_vld when not full, or when full with a pop in the same cycle.
REQ-024 SHALL drop the word and pulse ovfl_err one cycle later when in_vld, FIFO full and no pop.
REQ-025 SHALL assert ram_wr_req the cycle after a push into empty FIFO (1-cycle latency), with ram_wdata=FIFO head.
REQ-026 SHALL hold ram_wr_req, ram_waddr, ram_wdata stable until ram_wr_ack=1; pop on req&ack.
REQ-027 SHALL keep ram_wr_req high back-to-back after ack while FIFO holds another word (one word/cycle max).
REQ-028 SHALL compute addr18 = latched saddr + 4*count, 18-bit modulo (carry discarded).
REQ-029 SHALL pulse xfer_done the cycle after the ack of word words-1; circ_mode=1: count->0, stay RUN; circ_mode=0: enter DONE, flush remaining FIFO words, each flushed word pulses ovfl_err.
REQ-030 SHALL pulse half_done the cycle after the ack of word words/2-1 (not generated when words=1).
REQ-031 SHALL, on dma_en falling with req pending, complete that handshake, then flush and enter IDLE.
REQ-032 SHALL give frame_start during a pending handshake lower priority: complete ack first, apply restart next cycle.
REQ-033 SHALL ignore dma_saddr/dma_len changes except at frame_start.

Reset
REQ-034 SHALL, on rst=1, enter IDLE, empty FIFO, clear counters; ram_wr_req=0, ram_waddr=0, ram_wdata=0, busy=0, half_done=0, xfer_done=0, ovfl_err=0.
REQ-035 SHALL let rst abort a pending handshake (RAM side reset together).

Structure
REQ-036 SHALL place state encoding and FIFO_DEPTH default in shared package dcmi_pkg.
REQ-037 SHALL implement FIFO as sub-module dcmi_wfifo (sync, count-based full/empty).

Verification
REQ-038 saddr=0x100, len=16, ack tied 1, 4 in_vld back-to-back -> waddr 0x100,0x104,0x108,0x10C; half_done after 2nd ack; xfer_done after 4th; DONE.
REQ-039 ack held 0, 5 in_vld, depth 4 -> 4 words buffered, 1 ovfl_err pulse, req held with waddr=saddr.
REQ-040 circ_mode=1, saddr=0x3FFFC, len=8 -> waddr 0x3FFFC,0x00000, xfer_done, then 0x3FFFC again.
REQ-041 len=0 + frame_start -> DONE, xfer_done 1 cycle later, ram_wr_req never asserted.
REQ-042 dma_en drop while req=1, ack after 3 cycles -> handshake completes, FIFO flushed, IDLE, busy=0.
REQ-043 rst mid-RUN with req=1 -> all outputs 0 next cycle, IDLE.
